i2s_tx_axis: RTL and testbench

Parametrised I2S/left-justified transmitter fed by an AXI4-Stream slave through an internal sample FIFO. It generates BCLK, LRCLK and SDATA from the single system clock with a programmable divider, slot width and sample width. Channel-tagged words use the same packing the receive path already uses: channel flag in the MSB, sample in the LSBs. It replaces the fixed 24-bit WM8731 sender and adds underrun and misalignment detection plus a runtime format select.

---
 rtl/i2s_tx_axis.sv | 157 +++++++++++++++
 tb/tb_i2s_tx_axis.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_axis.sv
// I2S / left-justified serial transmitter fed from an AXI4-Stream slave through a small sample FIFO.
// BCLK and LRCLK are derived from the system clock; underrun and channel-misalignment are sticky flags.
module i2s_tx_axis #(
   parameter int C_S_AXIS_TDATA_WIDTH = 32,
   parameter int I2S_DATA_BIT_WIDTH   = 24,
   parameter int SLOT_WIDTH           = 32,
   parameter int BCLK_DIV             = 4,
   parameter int FIFO_DEPTH           = 8
) (
   input  logic                                S_AXIS_ACLK,
   input  logic                                S_AXIS_ARESETN,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
   input  logic                                S_AXIS_TVALID,
   output logic                                S_AXIS_TREADY,
   input  logic                                en,
   input  logic                                fmt_lj,
   input  logic                                clr_err,
   output logic                                BCLK,
   output logic                                LRCLK,
   output logic                                SDATA,
   output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
   output logic                                underrun,
   output logic                                misalign
);

   localparam int TW  = C_S_AXIS_TDATA_WIDTH;
   localparam int DW  = I2S_DATA_BIT_WIDTH;
   localparam int SW  = SLOT_WIDTH;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int DVW = $clog2(BCLK_DIV);
   localparam int BW  = $clog2(SLOT_WIDTH + 1);

   // The FIFO keeps only the channel flag and the sample; padding bits are dropped at the input.
   logic [DW:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            ready_q;
   logic            wr_en, rd_en, empty;
   logic [DW:0]     head;
   logic            unused_tdata;

   logic            run;
   logic [DVW-1:0]  div_cnt;
   logic [BW-1:0]   bit_cnt;
   logic            bclk_q, lr_q, sd_q, last_lj, fmt_q;
   logic [SW-1:0]   shreg, shreg_n, load_word;
   logic            start, fall_tick, slot_end, sse, lr_n;
   logic            set_ur, set_ma, fmt_eff, lj_bit;

   assign unused_tdata  = ^S_AXIS_TDATA;
   assign empty         = (count == '0);
   assign head          = mem[rd_ptr];
   assign S_AXIS_TREADY = ready_q && (count != (AW+1)'(FIFO_DEPTH));
   assign wr_en         = S_AXIS_TVALID && S_AXIS_TREADY;
   assign rd_en         = sse && !empty;
   assign fifo_level    = count;
   assign BCLK          = bclk_q;
   assign LRCLK         = lr_q;
   assign SDATA         = sd_q;

   always_ff @(posedge S_AXIS_ACLK) begin
      if (wr_en) mem[wr_ptr] <= {S_AXIS_TDATA[TW-1], S_AXIS_TDATA[DW-1:0]};
   end

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // A slot starts either on the first enabled cycle or on the BCLK fall that ends the previous slot.
   always_comb begin
      start     = en && !run;
      fall_tick = run && en && bclk_q && (div_cnt == DVW'(BCLK_DIV - 1));
      slot_end  = fall_tick && (bit_cnt == BW'(SLOT_WIDTH - 1));
      sse       = start || slot_end;
      lr_n      = start ? 1'b0 : ~lr_q;
      load_word = '0;
      load_word[SW-1 -: DW] = head[DW-1:0];
      set_ur    = sse && empty;
      set_ma    = sse && !empty && (head[DW] != lr_n);
      shreg_n   = shreg;
      if (sse)            shreg_n = (set_ur || set_ma) ? '0 : load_word;
      else if (fall_tick) shreg_n = shreg << 1;
      fmt_eff   = (sse && !lr_n) ? fmt_lj : fmt_q;
      lj_bit    = shreg_n[SW-1];
   end

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         run     <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
         bclk_q  <= 1'b0;
         lr_q    <= 1'b0;
         sd_q    <= 1'b0;
         last_lj <= 1'b0;
         fmt_q   <= 1'b0;
         shreg   <= '0;
      end else if (!en) begin
         run     <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
         bclk_q  <= 1'b0;
         lr_q    <= 1'b0;
         sd_q    <= 1'b0;
         last_lj <= 1'b0;
         shreg   <= '0;
      end else begin
         run   <= 1'b1;
         shreg <= shreg_n;
         if (sse) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk_q  <= 1'b0;
            lr_q    <= lr_n;
            if (!lr_n) fmt_q <= fmt_lj;
            sd_q    <= fmt_eff ? lj_bit : last_lj;
            last_lj <= lj_bit;
         end else if (div_cnt == DVW'(BCLK_DIV - 1)) begin
            div_cnt <= '0;
            bclk_q  <= ~bclk_q;
            // last_lj carries the LJ bit one BCLK late for the I2S delay.
            if (bclk_q) begin
               bit_cnt <= bit_cnt + 1'b1;
               sd_q    <= fmt_eff ? lj_bit : last_lj;
               last_lj <= lj_bit;
            end
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         underrun <= 1'b0;
         misalign <= 1'b0;
      end else begin
         underrun <= (underrun && !clr_err) || set_ur;
         misalign <= (misalign && !clr_err) || set_ma;
      end
   end

endmodule

// File: tb/tb_i2s_tx_axis.sv
// Bench for i2s_tx_axis: captures SDATA/LRCLK at every BCLK rise and compares whole slots
// against a queue-based reference model of the FIFO, slot and I2S/LJ framing rules.
module tb_i2s_tx_axis;

   localparam int TW    = 32;
   localparam int DW    = 24;
   localparam int SW    = 32;
   localparam int DIV   = 4;
   localparam int DEPTH = 8;
   localparam int PADW  = TW - 1 - DW;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [TW-1:0]   tdata = '0;
   logic            tvalid = 1'b0;
   logic            tready;
   logic            en = 1'b0;
   logic            fmt_lj = 1'b0;
   logic            clr_err = 1'b0;
   logic            bclk, lrclk, sdata, underrun, misalign;
   logic [$clog2(DEPTH):0] fifo_level;

   always #5 clk = ~clk;

   i2s_tx_axis #(
      .C_S_AXIS_TDATA_WIDTH(TW), .I2S_DATA_BIT_WIDTH(DW), .SLOT_WIDTH(SW),
      .BCLK_DIV(DIV), .FIFO_DEPTH(DEPTH)
   ) dut (
      .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .S_AXIS_TDATA(tdata),
      .S_AXIS_TVALID(tvalid), .S_AXIS_TREADY(tready), .en(en), .fmt_lj(fmt_lj),
      .clr_err(clr_err), .BCLK(bclk), .LRCLK(lrclk), .SDATA(sdata),
      .fifo_level(fifo_level), .underrun(underrun), .misalign(misalign)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Receiver: sample at each BCLK rise, observed on the falling system-clock edge.
   int   cyc = 0;
   logic bclk_prev = 1'b0;
   logic cap_lr[$];
   logic cap_sd[$];
   int   cap_t[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bclk && !bclk_prev) begin
         cap_lr.push_back(lrclk);
         cap_sd.push_back(sdata);
         cap_t.push_back(cyc);
      end
      bclk_prev = bclk;
   end

   // Reference model state
   logic [DW:0]    model_q[$];
   logic [SW-1:0]  exp_sd[$];
   logic [SW-1:0]  exp_lr[$];
   logic           exp_ur = 1'b0;
   logic           exp_ma = 1'b0;

   task automatic model_run(input int n, input logic fmt);
      logic          lj[$];
      logic          st[$];
      logic [SW-1:0] slot, v;
      logic [DW:0]   w;
      logic          ch;
      exp_sd.delete();
      exp_lr.delete();
      for (int s = 0; s < n; s++) begin
         ch   = (s % 2 == 1);
         slot = '0;
         if (model_q.size() == 0) begin
            exp_ur = 1'b1;
         end else begin
            w = model_q.pop_front();
            if (w[DW] !== ch) exp_ma = 1'b1;
            else              slot = SW'(w[DW-1:0]) << (SW - DW);
         end
         for (int b = SW - 1; b >= 0; b--) lj.push_back(slot[b]);
      end
      st = lj;
      if (!fmt) begin
         st.push_front(1'b0);
         void'(st.pop_back());
      end
      for (int s = 0; s < n; s++) begin
         v = '0;
         for (int b = 0; b < SW; b++) v[SW-1-b] = st[s*SW + b];
         exp_sd.push_back(v);
         exp_lr.push_back((s % 2 == 1) ? {SW{1'b1}} : {SW{1'b0}});
      end
   endtask

   task automatic push(input logic ch, input logic [DW-1:0] sample);
      int t = 0;
      @(negedge clk);
      tdata  = {ch, PADW'($urandom), sample};
      tvalid = 1'b1;
      while (!tready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!tready) check("push_timeout", 64'(tready), 64'd1);
      else         model_q.push_back({ch, sample});
      @(negedge clk);
      tvalid = 1'b0;
   endtask

   task automatic wait_bits(input int k);
      int t = 0;
      while (cap_sd.size() < k && t < k * 2 * DIV + 100) begin
         @(negedge clk);
         t++;
      end
   endtask

   task automatic run_slots(input int n, input logic fmt, input int probe);
      logic [SW-1:0] v_sd, v_lr;
      @(negedge clk) clr_err = 1'b1;
      @(negedge clk) clr_err = 1'b0;
      exp_ur = 1'b0;
      exp_ma = 1'b0;
      cap_sd.delete();
      cap_lr.delete();
      cap_t.delete();
      fmt_lj = fmt;
      model_run(n, fmt);
      en = 1'b1;
      if (probe == 1) begin
         @(negedge clk);
         @(negedge clk);
         check("underrun_first_sse", 64'(underrun), 64'd1);
         clr_err = 1'b1;
         @(negedge clk);
         clr_err = 1'b0;
         check("underrun_cleared", 64'(underrun), 64'd0);
         wait_bits(SW + 2);
         check("underrun_next_sse", 64'(underrun), 64'd1);
      end else if (probe == 2) begin
         @(negedge clk);
         check("bp_level_after_pop", 64'(fifo_level), 64'(DEPTH - 1));
         check("bp_tready_after_pop", 64'(tready), 64'd1);
      end
      wait_bits(n * SW);
      en = 1'b0;
      check("bits_captured", 64'(cap_sd.size()), 64'(n * SW));
      if (cap_sd.size() == n * SW) begin
         for (int s = 0; s < n; s++) begin
            for (int b = 0; b < SW; b++) begin
               v_sd[SW-1-b] = cap_sd[s*SW + b];
               v_lr[SW-1-b] = cap_lr[s*SW + b];
            end
            check($sformatf("slot%0d_sdata", s), 64'(v_sd), 64'(exp_sd[s]));
            check($sformatf("slot%0d_lrclk", s), 64'(v_lr), 64'(exp_lr[s]));
         end
      end
      @(negedge clk);
      check("underrun_flag", 64'(underrun), 64'(exp_ur));
      check("misalign_flag", 64'(misalign), 64'(exp_ma));
      check("fifo_level_end", 64'(fifo_level), 64'(model_q.size()));
   endtask

   initial begin
      int acc;
      int n, np;
      logic ch;
      logic [DW-1:0] smp;

      // Power-on reset
      repeat (3) @(negedge clk);
      check("rst_bclk", 64'(bclk), 64'd0);
      check("rst_lrclk", 64'(lrclk), 64'd0);
      check("rst_sdata", 64'(sdata), 64'd0);
      check("rst_tready", 64'(tready), 64'd0);
      check("rst_level", 64'(fifo_level), 64'd0);
      check("rst_flags", 64'({underrun, misalign}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("tready_after_release", 64'(tready), 64'd1);

      // Left-justified frame with the reference words
      push(1'b0, 24'h800001);
      push(1'b1, 24'h7FFFFF);
      check("level_two_words", 64'(fifo_level), 64'd2);
      run_slots(2, 1'b1, 0);
      if (cap_t.size() >= 2) check("bclk_period", 64'(cap_t[1] - cap_t[0]), 64'(2 * DIV));
      else                   check("bclk_period_samples", 64'(cap_t.size()), 64'd2);

      // Same words in I2S format
      push(1'b0, 24'h800001);
      push(1'b1, 24'h7FFFFF);
      run_slots(2, 1'b0, 0);

      // Two frames with an empty FIFO
      run_slots(4, 1'b1, 1);

      // Reset mid-frame, with underrun still set from above
      push(1'b0, 24'($urandom));
      push(1'b1, 24'($urandom));
      fmt_lj = 1'b1;
      cap_sd.delete();
      cap_lr.delete();
      @(negedge clk) en = 1'b1;
      wait_bits(10);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_bclk", 64'(bclk), 64'd0);
      check("midrst_lrclk", 64'(lrclk), 64'd0);
      check("midrst_sdata", 64'(sdata), 64'd0);
      check("midrst_flags", 64'({underrun, misalign}), 64'd0);
      check("midrst_level", 64'(fifo_level), 64'd0);
      check("midrst_tready", 64'(tready), 64'd0);
      en = 1'b0;
      model_q.delete();
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      check("midrst_tready_release", 64'(tready), 64'd1);

      // Misaligned first word, then resynchronised stream
      push(1'b1, 24'($urandom));
      push(1'b1, 24'($urandom));
      push(1'b0, 24'($urandom));
      push(1'b1, 24'($urandom));
      run_slots(4, 1'b1, 0);

      // Backpressure: fill the FIFO with TVALID held high while disabled
      acc = 0;
      @(negedge clk);
      tvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         ch    = (acc % 2 == 1);
         smp   = 24'($urandom);
         tdata = {ch, PADW'($urandom), smp};
         if (!tready) break;
         model_q.push_back({ch, smp});
         acc++;
         @(negedge clk);
      end
      tvalid = 1'b0;
      check("bp_accepts", 64'(acc), 64'(DEPTH));
      check("bp_level_full", 64'(fifo_level), 64'(DEPTH));
      check("bp_tready_full", 64'(tready), 64'd0);
      run_slots(DEPTH, 1'b0, 2);

      // Randomised runs with occasional wrong tags and short supply
      for (int r = 0; r < 4; r++) begin
         n  = $urandom_range(2, 6);
         np = $urandom_range(n - 1, n);
         for (int k = 0; k < np; k++) begin
            ch = (k % 2 == 1) ^ ($urandom_range(0, 5) == 0);
            push(ch, 24'($urandom));
         end
         run_slots(n, 1'($urandom_range(0, 1)), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
